instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter AW, default 5: instruction ROM address width.
REQ-002 SHALL have parameter DW, default 9: instruction word width.
REQ-003 SHALL have parameter DEPTH, default 2: prefetch queue entries (power of 2, >=2).
REQ-004 SHALL have port Clock, input, 1: single clock; all state updates on posedge.
REQ-005 SHALL have port Resetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port rom_addr, output, AW: fetch address to ROM (ROM samples on posedge Clock; data valid the following cycle).
REQ-007 SHALL have port rom_data, input, DW: ROM read data, 1-cycle synchronous latency.
REQ-008 SHALL have port DIN, output, DW: head-of-queue instruction to the processor.
REQ-009 SHALL have port Valid, output, 1: DIN holds a valid instruction.
REQ-010 SHALL have port pc_inc, input, 1: consumer pop; effective only when Valid=1.
REQ-011 SHALL have port pc_addr, output, AW: ROM address of the instruction on DIN.
REQ-012 SHALL have port LoadPC, input, 1: redirect request.
REQ-013 SHALL have port NewPC, input, AW: redirect target address.
REQ-014 SHALL have port Count, output, $clog2(DEPTH)+1: queue occupancy.

Function
REQ-015 SHALL hold fetch pointer fa; rom_addr SHALL equal fa (registered, not combinational from inputs).
REQ-016 SHALL issue a read in a cycle when Count + pend - pop < DEPTH, where pend = read in flight, pop = Valid & pc_inc; issuing SHALL set pend for the next cycle and increment fa.
REQ-017 fa SHALL wrap from 2^AW-1 to 0 without stall or flag.
REQ-018 When pend=1, rom_data SHALL be written with its address (fa at issue) into the queue tail at that cycle's posedge.
REQ-019 First instruction: issue in cycle 0 after reset release, Valid=1 from cycle 2 (two posedges of latency); no combinational bypass.
REQ-020 With pc_inc held high, SHALL sustain one instruction per cycle indefinitely.
REQ-021 Simultaneous push and pop SHALL leave Count unchanged; pop on empty SHALL be ignored; overflow SHALL be impossible by REQ-016.
REQ-022 DIN/pc_addr SHALL be stable while Valid=1 and pc_inc=0.
REQ-023 LoadPC=1 SHALL, at that posedge: empty queue (Count=0, Valid=0), cancel in-flight read (pend=0, returning data discarded), set fa=NewPC.
REQ-024 LoadPC SHALL take priority over simultaneous pc_inc and push; next instruction SHALL appear with Valid=1 two cycles after the LoadPC edge.
REQ-025 Queue SHALL be circular with wrap-around read/write pointers of $clog2(DEPTH) bits.

Reset
REQ-026 Resetn=0 SHALL asynchronously force fa=0, pend=0, Count=0, Valid=0, DIN=0, pc_addr=0, rom_addr=0.
REQ-027 Reset asserted mid-operation SHALL discard queue contents and any in-flight read; fetch SHALL restart at address 0.

Structure
REQ-028 Shared package simproc_pkg SHALL hold AW, DW constants and typedefs addr_t (logic [AW-1:0]), instr_t (logic [DW-1:0]), fetch_entry_t (struct {addr_t addr; instr_t instr;}).
REQ-029 Queue SHALL be sub-module fetch_fifo (DEPTH entries of fetch_entry_t, push/pop/flush, count); issue logic and fa in instr_fetch.

Verification
REQ-030 ROM word[i]=i+9'h100; reset release, pc_inc=1 -> Valid rises cycle 2, DIN=9'h100,9'h101,... one per cycle, pc_addr 0,1,2,...
REQ-031 pc_inc=0 after reset -> Count settles at 2, rom_addr stops at 2, DIN=9'h100 held; pc_inc pulse -> DIN=9'h101, rom_addr advances to 3.
REQ-032 Run 40 cycles with pc_inc=1 -> pc_addr sequence 31 then 0, DIN=9'h11F then 9'h100, no bubble.
REQ-033 LoadPC=1, NewPC=5'd20 with pc_inc=1 and queue full -> Valid=0 next cycle, old in-flight data dropped, DIN=9'h114 two cycles after redirect.
REQ-034 Random pc_inc pattern for 500 cycles vs reference model -> DIN/pc_addr sequence matches in-order, Count never exceeds 2.
REQ-035 Resetn low for 1 cycle mid-stream with Count=2 -> all outputs 0 immediately; restart yields DIN=9'h100 at pc_addr 0.

Source files
------------

// File: rtl/simproc_pkg.sv
// ---------------------------------------------------------------------------
// simproc_pkg
// Shared constants and types for the simple processor front end.
//   AW            : instruction ROM address width
//   DW            : instruction word width
//   addr_t        : ROM address
//   instr_t       : instruction word
//   fetch_entry_t : one prefetched instruction tagged with its ROM address
//   addr_next()   : address increment, wraps naturally at 2^AW
// ---------------------------------------------------------------------------
package simproc_pkg;

    localparam int AW = 5;
    localparam int DW = 9;

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] instr_t;

    typedef struct packed {
        addr_t  addr;
        instr_t instr;
    } fetch_entry_t;

    function automatic addr_t addr_next(input addr_t a);
        return a + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Circular prefetch queue of fetch_entry_t with wrap-around pointers.
//   Clock     : clock, all updates on posedge
//   Resetn    : asynchronous active-low reset, empties queue and clears storage
//   push      : write push_data at the tail
//   push_data : entry to write
//   pop       : drop the head entry (ignored when empty)
//   flush     : empty the queue; wins over push and pop in the same cycle
//   head      : entry at the head of the queue (stale when count is 0)
//   count     : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo
    import simproc_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic do_push;
    logic do_pop;

    // Pop on empty is dropped; a push into a full queue is only accepted
    // when a pop frees the slot in the same cycle.
    always_comb begin
        do_pop  = pop && (count_reg != '0);
        do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage is reset so the head reads back as zero out of reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge Clock or negedge Resetn) begin
                if (!Resetn) begin
                    mem_reg[gi] <= '0;
                end else if (!flush && do_push && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction prefetcher between a 1-cycle-latency synchronous ROM and the
// processor. Keeps the fetch pointer and the in-flight flag; the fetched
// words are buffered in fetch_fifo.
//   Clock    : clock, all updates on posedge
//   Resetn   : asynchronous active-low reset, restarts fetch at address 0
//   rom_addr : fetch address to ROM (registered fetch pointer)
//   rom_data : ROM read data for the address issued the previous cycle
//   DIN      : instruction at the head of the queue
//   Valid    : DIN holds a valid instruction
//   pc_inc   : consumer pop, effective only while Valid is high
//   pc_addr  : ROM address of the instruction on DIN
//   LoadPC   : redirect, flushes the queue and cancels the in-flight read
//   NewPC    : redirect target address
//   Count    : queue occupancy
// AW/DW must match the package constants, since the queue stores
// fetch_entry_t.
// ---------------------------------------------------------------------------
module instr_fetch
    import simproc_pkg::*;
#(
    parameter int  AW    = simproc_pkg::AW,
    parameter int  DW    = simproc_pkg::DW,
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          Clock,
    input  logic          Resetn,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] DIN,
    output logic          Valid,
    input  logic          pc_inc,
    output logic [AW-1:0] pc_addr,
    input  logic          LoadPC,
    input  logic [AW-1:0] NewPC,
    output logic [CW-1:0] Count
);

    logic [AW-1:0] fa_reg;
    logic [AW-1:0] pend_addr_reg;
    logic          pend_reg;

    logic          pop;
    logic          issue;
    logic [CW:0]   committed;

    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic [CW-1:0] count;

    // Slots already spoken for after this edge: entries held plus the word
    // in flight, minus the one leaving. A new read is issued only if that
    // leaves room, which is what keeps the queue from overflowing.
    always_comb begin
        pop       = Valid && pc_inc;
        committed = (CW+1)'(count) + (CW+1)'(pend_reg) - (CW+1)'(pop);
        issue     = !LoadPC && (committed < (CW+1)'(DEPTH));
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            fa_reg        <= '0;
            pend_reg      <= 1'b0;
            pend_addr_reg <= '0;
        end else if (LoadPC) begin
            // Dropping pend makes the word returning next cycle be ignored.
            fa_reg   <= NewPC;
            pend_reg <= 1'b0;
        end else begin
            pend_reg <= issue;
            if (issue) begin
                fa_reg        <= addr_next(fa_reg);
                pend_addr_reg <= fa_reg;
            end
        end
    end

    assign push_entry = '{addr: pend_addr_reg, instr: rom_data};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .push      (pend_reg && !LoadPC),
        .push_data (push_entry),
        .pop       (pop && !LoadPC),
        .flush     (LoadPC),
        .head      (head),
        .count     (count)
    );

    assign rom_addr = fa_reg;
    assign DIN      = head.instr;
    assign pc_addr  = head.addr;
    assign Count    = count;
    assign Valid    = (count != '0);

endmodule
